// File: rtl/skolem_pkg.sv
// skolem_pkg: shared state encoding, config selectors and table-size helpers
package skolem_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;
  localparam logic CFG_SEL_SKOLEM = 1'b0;
  localparam logic CFG_SEL_SPEC = 1'b1;
  function automatic int skolem_depth(input int nx);
    return 1 << nx;
  endfunction
  function automatic int spec_depth(input int nx, input int ny);
    return 1 << (nx + ny);
  endfunction
endpackage

// File: rtl/skolem_lut_bank.sv
// skolem_lut_bank: Skolem and spec truth tables with a write port and combinational eval
module skolem_lut_bank
  import skolem_pkg::*;
#(
  parameter int NX = 5,
  parameter int NY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             sel,
  input  logic [1:0]       out,
  input  logic [NX+NY-1:0] addr,
  input  logic             data,
  input  logic [NX-1:0]    x,
  output logic [NY-1:0]    y,
  output logic             ok
);
  localparam int SKD = skolem_depth(NX);
  localparam int SPD = spec_depth(NX, NY);
  logic [NY-1:0][SKD-1:0] sk_q;
  logic [SPD-1:0] spec_q;
  // spec table: bit {y, x} holds F(x, y)
  always_ff @(posedge clk or posedge rst)
    if (rst) spec_q <= '0;
    else if (we && sel == CFG_SEL_SPEC) spec_q[addr] <= data;
  for (genvar j = 0; j < NY; j++) begin : g_row
    // Skolem row j: only indices below NY ever match, so out-of-range writes fall away
    always_ff @(posedge clk or posedge rst)
      if (rst) sk_q[j] <= '0;
      else if (we && sel == CFG_SEL_SKOLEM && out == 2'(j)) sk_q[j][addr[NX-1:0]] <= data;
    assign y[j] = sk_q[j][x];
  end
  assign ok = spec_q[{y, x}];
endmodule

// File: rtl/skolem_sweep_checker.sv
// skolem_sweep_checker: stream evaluator and exhaustive sweep checker for Skolem vectors
module skolem_sweep_checker
  import skolem_pkg::*;
#(
  parameter int NX = 5,
  parameter int NY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [1:0]       cfg_out,
  input  logic [NX+NY-1:0] cfg_addr,
  input  logic             cfg_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [NX-1:0]    s_x,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [NY-1:0]    m_y,
  output logic             m_ok,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [NX:0]      fail_cnt,
  output logic [NX-1:0]    first_fail_x
);
  state_e state_q, state_d;
  logic [NX-1:0] cnt_q, ffx_q, ex;
  logic [NX:0] fail_q;
  logic [NY-1:0] my_q, ey;
  logic mv_q, mok_q, eok, acc, go, last;
  assign busy = state_q == SWEEP;
  assign done = state_q == DONE;
  assign s_ready = ~rst & ~busy & (~mv_q | m_ready);
  assign acc = s_valid & s_ready;
  assign go = start & ~busy & ~mv_q & ~acc;
  assign last = cnt_q == '1;
  assign ex = busy ? cnt_q : s_x;
  assign m_valid = mv_q;
  assign m_y = my_q;
  assign m_ok = mok_q;
  assign fail_cnt = fail_q;
  assign first_fail_x = ffx_q;
  skolem_lut_bank #(.NX(NX), .NY(NY)) u_bank (
    .clk(clk), .rst(rst), .we(cfg_we & ~busy), .sel(cfg_sel), .out(cfg_out),
    .addr(cfg_addr), .data(cfg_data), .x(ex), .y(ey), .ok(eok)
  );
  // sweep ends after the all-ones assignment; start only lands outside a sweep
  always_comb state_d = busy ? (last ? DONE : SWEEP) : (go ? SWEEP : state_q);
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // sweep counter and violation bookkeeping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      fail_q <= '0;
      ffx_q <= '0;
    end else if (go) begin
      cnt_q <= '0;
      fail_q <= '0;
      ffx_q <= '0;
    end else if (busy) begin
      if (!eok) fail_q <= fail_q + (NX+1)'(1);
      if (!eok && fail_q == '0) ffx_q <= cnt_q;
      if (!last) cnt_q <= cnt_q + NX'(1);
    end
  // one-deep result holding register for the stream path
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mv_q <= 1'b0;
      my_q <= '0;
      mok_q <= 1'b0;
    end else if (acc) begin
      mv_q <= 1'b1;
      my_q <= ey;
      mok_q <= eok;
    end else if (m_ready) mv_q <= 1'b0;
endmodule

// File: tb/tb_skolem_sweep_checker.sv
// tb_skolem_sweep_checker: randomized and directed checks against a table-level model
module tb_skolem_sweep_checker;
  localparam int NX = 5;
  localparam int NY = 2;
  localparam int NXV = 1 << NX;
  localparam int NS = 1 << (NX + NY);
  logic clk = 0, rst = 1;
  logic cfg_we = 0, cfg_sel = 0, cfg_data = 0;
  logic [1:0] cfg_out = 0;
  logic [NX+NY-1:0] cfg_addr = 0;
  logic s_valid = 0, m_ready = 0, start = 0;
  logic [NX-1:0] s_x = 0;
  logic s_ready, m_valid, m_ok, busy, done;
  logic [NY-1:0] m_y;
  logic [NX:0] fail_cnt;
  logic [NX-1:0] first_fail_x;
  int n_chk = 0, n_err = 0;
  bit sk[NY][NXV];
  bit spec[NS];
  bit exp_mv = 0, exp_ok = 0;
  logic [NY-1:0] exp_my = 0;

  skolem_sweep_checker #(.NX(NX), .NY(NY)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_out(cfg_out),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_ok(m_ok),
    .start(start), .busy(busy), .done(done), .fail_cnt(fail_cnt), .first_fail_x(first_fail_x)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NY-1:0] sk_eval(input int x);
    logic [NY-1:0] y = '0;
    for (int j = 0; j < NY; j++) y[j] = sk[j][x];
    return y;
  endfunction

  function automatic bit f_at(input int x);
    return spec[(int'(sk_eval(x)) << NX) + x];
  endfunction

  task automatic clear_model();
    foreach (spec[i]) spec[i] = 0;
    for (int j = 0; j < NY; j++) for (int x = 0; x < NXV; x++) sk[j][x] = 0;
    exp_mv = 0;
  endtask

  task automatic wr(input bit sel, input int out, input int addr, input bit data);
    @(posedge clk); #1;
    cfg_we = 1; cfg_sel = sel; cfg_out = 2'(out); cfg_addr = (NX+NY)'(addr); cfg_data = data;
    @(posedge clk); #1;
    cfg_we = 0;
    if (sel) spec[addr] = data;
    else if (out < NY) sk[out][addr] = data;
  endtask

  task automatic step(input bit sv, input int sx, input bit mr);
    @(posedge clk); #1;
    s_valid = sv; s_x = NX'(sx); m_ready = mr;
    @(negedge clk);
    chk("m_valid", m_valid, exp_mv);
    if (exp_mv) begin
      chk("m_y", m_y, exp_my);
      chk("m_ok", m_ok, exp_ok);
    end
    chk("s_ready", s_ready, !exp_mv || mr);
    if (sv && (!exp_mv || mr)) begin
      exp_mv = 1; exp_my = sk_eval(sx); exp_ok = f_at(sx);
    end else if (mr) exp_mv = 0;
  endtask

  task automatic sweep(input bit mid_start, input bit mid_wr);
    int n = 0, ef = 0, efx = 0, idx;
    for (int x = NXV - 1; x >= 0; x--) if (!f_at(x)) begin ef++; efx = x; end
    idx = (int'(sk_eval(9)) << NX) + 9;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      start = mid_start && n == 10;
      cfg_we = mid_wr && n == 5; cfg_sel = 1; cfg_addr = (NX+NY)'(idx); cfg_data = !spec[idx];
    end
    start = 0; cfg_we = 0;
    chk("sweep_len", n, NXV);
    chk("done", done, 1);
    chk("fail_cnt", fail_cnt, ef);
    if (ef != 0) chk("first_fail_x", first_fail_x, efx);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_outs", {m_valid, m_y, m_ok, busy, done, fail_cnt, first_fail_x}, 0);
    rst = 0;
    @(negedge clk);
    chk("rel_s_ready", s_ready, 1);
    for (int a = 0; a < NS; a++) wr(1, 0, a, 1'($urandom));
    for (int j = 0; j < NY; j++) for (int x = 0; x < NXV; x++) wr(0, j, x, 1'($urandom));
    wr(0, 2, 5, !sk[0][5]);
    wr(0, 3, 6, !sk[1][6]);
    for (int i = 0; i < 150; i++) step(1'($urandom), $urandom_range(0, NXV - 1), 1'($urandom));
    step(0, 0, 1);
    sweep(1, 1);
    step(1, 9, 1);
    step(1, 5, 1);
    step(1, 6, 1);
    step(0, 0, 1);
    for (int a = 0; a < NS; a++) if (!spec[a]) wr(1, 0, a, 1);
    sweep(0, 0);
    for (int j = 0; j < NY; j++) for (int x = 0; x < NXV; x++) if (sk[j][x]) wr(0, j, x, 0);
    wr(0, 0, 7, 1);
    wr(0, 1, 7, 1);
    wr(1, 0, (3 << NX) + 7, 0);
    sweep(0, 0);
    sweep(1, 0);
    step(1, 7, 0);
    step(1, 3, 0);
    step(1, 3, 0);
    step(1, 3, 0);
    step(1, 3, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    begin
      int n = 0;
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      while (n < 100 && n != 11) begin
        @(negedge clk);
        if (!busy) break;
        n++;
      end
      chk("pre_rst_busy_cycles", n, 11);
      rst = 1;
      #2;
      chk("midrst_s_ready", s_ready, 0);
      chk("midrst_outs", {m_valid, m_y, m_ok, busy, done, fail_cnt, first_fail_x}, 0);
      @(negedge clk);
      rst = 0;
      clear_model();
      @(negedge clk);
      chk("post_rst_s_ready", s_ready, 1);
      chk("post_rst_idle", {busy, done}, 0);
    end
    for (int i = 0; i < 20; i++) step(1, $urandom_range(0, NXV - 1), 1'($urandom));
    step(0, 0, 1);
    sweep(0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
